irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt lines (legal range 1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of the number and config data buses.
REQ-003 SHALL have port I_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-004 SHALL have port I_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port I_irq, input, NUM_IRQ bits: raw interrupt lines, synchronous to I_clk.
REQ-006 SHALL have port I_irq_ack, input, 1 bit: core acknowledge pulse.
REQ-007 SHALL have port I_eoi, input, 1 bit: end-of-interrupt pulse, issued by the core on return from the ISR.
REQ-008 SHALL have port I_cfg_write, input, 1 bit: config register write strobe.
REQ-009 SHALL have port I_cfg_addr, input, 2 bits: config register select (0 MASK, 1 MODE, 2 PENDING).
REQ-010 SHALL have port I_cfg_data, input, DATA_WIDTH bits: config write data; bits above NUM_IRQ-1 ignored.
REQ-011 SHALL have port O_cfg_data, output, DATA_WIDTH bits: registered read-back of the register at I_cfg_addr.
REQ-012 SHALL have port O_irq_active, output, 1 bit: request to the core.
REQ-013 SHALL have port O_irq_number, output, DATA_WIDTH bits: zero-extended winning channel index.
REQ-014 SHALL have port O_number_valid, output, 1 bit: O_irq_number is valid this cycle.
REQ-015 SHALL have port O_in_service, output, 1 bit: an ISR is in progress.

Function
REQ-016 MODE bit i SHALL select the trigger type for line i: 0 = level, 1 = rising edge.
REQ-017 Edge lines SHALL be detected against a registered copy of I_irq; each detected edge SHALL set PENDING[i] on the next edge of I_clk.
REQ-018 For level lines, PENDING[i] SHALL be set every cycle in which I_irq[i]=1.
REQ-019 A write of 1 to PENDING bit i SHALL clear PENDING[i] (write-1-to-clear); a set event in the same cycle SHALL win.
REQ-020 Eligible set SHALL be PENDING & MASK; the lowest eligible index SHALL be highest priority.
REQ-021 The FSM SHALL have the states IDLE, REQUEST, NUMBER and SERVICE.
REQ-022 IDLE -> REQUEST when the eligible set is non-zero; O_irq_active=1 in REQUEST only.
REQ-023 REQUEST -> IDLE without acknowledge if the eligible set becomes zero (masked or cleared).
REQ-024 REQUEST with I_irq_ack=1 SHALL latch the current winner into the in-service ID, clear that channel's PENDING bit if it is an edge line, and go to NUMBER.
REQ-025 NUMBER SHALL last exactly 1 cycle (the cycle after the ack): O_number_valid=1 and O_irq_number=ID; then SERVICE.
REQ-026 O_irq_number SHALL hold the latched ID from NUMBER until the next acknowledge.
REQ-027 In SERVICE, O_in_service SHALL be 1, no new request SHALL be raised, and pending capture SHALL continue.
REQ-028 SERVICE with I_eoi=1 SHALL go to IDLE; in IDLE the next request SHALL assert on the following cycle.
REQ-029 I_irq_ack outside REQUEST and I_eoi outside SERVICE SHALL be ignored.
REQ-030 The winner SHALL be sampled in the ack cycle; a higher-priority arrival after the ack SHALL wait until the EOI.
REQ-031 O_cfg_data SHALL update 1 cycle after I_cfg_addr changes; reads at address 3 SHALL return 0.

Reset
REQ-032 With I_reset=1 at a clock edge: FSM to IDLE; MASK, MODE, PENDING, ID and edge history cleared to 0; all outputs 0.
REQ-033 A reset during REQUEST, NUMBER or SERVICE SHALL abandon the interrupt with no EOI required.

Verification
REQ-034 MASK=0xFF, MODE=0, I_irq=0x08 -> O_irq_active=1 two cycles later; ack -> next cycle O_number_valid=1, O_irq_number=3.
REQ-035 MASK=0xFF, I_irq=0x24 simultaneously -> channel 2 is serviced first; after EOI, channel 5 is requested and serviced.
REQ-036 MODE=0x01, 1-cycle pulse on I_irq[0] -> PENDING=0x01; after ack, PENDING=0x00 while the line stays low.
REQ-037 MASK=0x00, I_irq=0xFF -> O_irq_active stays 0; MASK read-back returns 0x0000; writing MASK=0x80 -> request, number 7.
REQ-038 Reset asserted in SERVICE -> O_in_service=0 and all config registers read 0 on the next cycle.
REQ-039 NUM_IRQ=16, I_irq[15]=1 -> O_irq_number=16'h000F.

Source files
------------

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: per-line level/edge capture, mask, W1C pending,
// and a request/acknowledge/number/service handshake with the core.
module irq_ctrl #(
    parameter int NUM_IRQ    = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  I_clk,
    input  logic                  I_reset,
    input  logic [NUM_IRQ-1:0]    I_irq,
    input  logic                  I_irq_ack,
    input  logic                  I_eoi,
    input  logic                  I_cfg_write,
    input  logic [1:0]            I_cfg_addr,
    input  logic [DATA_WIDTH-1:0] I_cfg_data,
    output logic [DATA_WIDTH-1:0] O_cfg_data,
    output logic                  O_irq_active,
    output logic [DATA_WIDTH-1:0] O_irq_number,
    output logic                  O_number_valid,
    output logic                  O_in_service
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        NUMBER,
        SERVICE
    } state_t;

    state_t              state;
    logic [NUM_IRQ-1:0]  mask;
    logic [NUM_IRQ-1:0]  mode;
    logic [NUM_IRQ-1:0]  pending;
    logic [NUM_IRQ-1:0]  irq_prev;
    logic [ID_W-1:0]     id;

    logic [NUM_IRQ-1:0]  cfg_wdata;
    logic [NUM_IRQ-1:0]  eligible;
    logic [NUM_IRQ-1:0]  set_vec;
    logic [NUM_IRQ-1:0]  pending_clr;
    logic [NUM_IRQ-1:0]  pending_next;
    logic [ID_W-1:0]     winner;
    logic                ack_taken;
    logic                unused_cfg_bits;

    assign cfg_wdata       = I_cfg_data[NUM_IRQ-1:0];
    assign unused_cfg_bits = ^I_cfg_data;
    assign eligible        = pending & mask;
    assign set_vec         = (mode & I_irq & ~irq_prev) | (~mode & I_irq);
    assign ack_taken       = (state == REQUEST) && (eligible != '0) && I_irq_ack;
    assign O_irq_number    = DATA_WIDTH'(id);

    // Lowest eligible index wins, so scan downwards and let the last hit stand.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Clears are applied first so a set event in the same cycle wins.
    always_comb begin
        pending_clr = '0;
        if (I_cfg_write && (I_cfg_addr == 2'd2)) begin
            pending_clr = cfg_wdata;
        end
        if (ack_taken && mode[winner]) begin
            pending_clr[winner] = 1'b1;
        end
        pending_next = (pending & ~pending_clr) | set_vec;
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            mask       <= '0;
            mode       <= '0;
            pending    <= '0;
            irq_prev   <= '0;
            O_cfg_data <= '0;
        end else begin
            irq_prev <= I_irq;
            pending  <= pending_next;
            if (I_cfg_write && (I_cfg_addr == 2'd0)) begin
                mask <= cfg_wdata;
            end
            if (I_cfg_write && (I_cfg_addr == 2'd1)) begin
                mode <= cfg_wdata;
            end
            case (I_cfg_addr)
                2'd0:    O_cfg_data <= DATA_WIDTH'(mask);
                2'd1:    O_cfg_data <= DATA_WIDTH'(mode);
                2'd2:    O_cfg_data <= DATA_WIDTH'(pending);
                default: O_cfg_data <= '0;
            endcase
        end
    end

    // Outputs are registered alongside the state so each one is high exactly in its state.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state          <= IDLE;
            id             <= '0;
            O_irq_active   <= 1'b0;
            O_number_valid <= 1'b0;
            O_in_service   <= 1'b0;
        end else begin
            O_irq_active   <= 1'b0;
            O_number_valid <= 1'b0;
            O_in_service   <= 1'b0;
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        state        <= REQUEST;
                        O_irq_active <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (eligible == '0) begin
                        state <= IDLE;
                    end else if (I_irq_ack) begin
                        id             <= winner;
                        state          <= NUMBER;
                        O_number_valid <= 1'b1;
                    end else begin
                        O_irq_active <= 1'b1;
                    end
                end
                NUMBER: begin
                    state        <= SERVICE;
                    O_in_service <= 1'b1;
                end
                SERVICE: begin
                    if (I_eoi) begin
                        state <= IDLE;
                    end else begin
                        O_in_service <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_irq_ctrl;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int P_IDLE = 0, P_REQ = 1, P_NUM = 2, P_SVC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [N-1:0]  irq = '0;
    logic          ack = 1'b0, eoi = 1'b0, wr = 1'b0;
    logic [1:0]    addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] cfg_out, num;
    logic          active, valid, in_svc;

    irq_ctrl #(.NUM_IRQ(N), .DATA_WIDTH(DW)) dut (
        .I_clk(clk), .I_reset(rst), .I_irq(irq), .I_irq_ack(ack), .I_eoi(eoi),
        .I_cfg_write(wr), .I_cfg_addr(addr), .I_cfg_data(wdata),
        .O_cfg_data(cfg_out), .O_irq_active(active), .O_irq_number(num),
        .O_number_valid(valid), .O_in_service(in_svc)
    );

    logic        rst16 = 1'b1;
    logic [15:0] irq16 = '0;
    logic        ack16 = 1'b0, eoi16 = 1'b0, wr16 = 1'b0;
    logic [1:0]  addr16 = '0;
    logic [15:0] wdata16 = '0;
    logic [15:0] cfg16, num16;
    logic        active16, valid16, svc16;

    irq_ctrl #(.NUM_IRQ(16), .DATA_WIDTH(16)) dut16 (
        .I_clk(clk), .I_reset(rst16), .I_irq(irq16), .I_irq_ack(ack16), .I_eoi(eoi16),
        .I_cfg_write(wr16), .I_cfg_addr(addr16), .I_cfg_data(wdata16),
        .O_cfg_data(cfg16), .O_irq_active(active16), .O_irq_number(num16),
        .O_number_valid(valid16), .O_in_service(svc16)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    bit model_on     = 1'b0;

    bit [N-1:0]  m_mask = '0, m_mode = '0, m_pend = '0, m_prev = '0;
    int          m_phase = P_IDLE;
    int          m_id = 0;
    bit [DW-1:0] m_cfg = '0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending bits, priority pick and handshake phase derived from the rules directly.
    task automatic modelStep();
        bit [N-1:0] elig, np;
        int win;
        if (rst) begin
            m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
            m_phase = P_IDLE; m_id = 0; m_cfg = '0;
            return;
        end
        elig = m_pend & m_mask;
        win = -1;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i;
        case (addr)
            2'd0:    m_cfg = DW'(m_mask);
            2'd1:    m_cfg = DW'(m_mode);
            2'd2:    m_cfg = DW'(m_pend);
            default: m_cfg = '0;
        endcase
        np = m_pend;
        if (wr && addr == 2'd2) np = np & ~wdata[N-1:0];
        case (m_phase)
            P_IDLE: if (win >= 0) m_phase = P_REQ;
            P_REQ: begin
                if (win < 0) m_phase = P_IDLE;
                else if (ack) begin
                    m_id = win;
                    if (m_mode[win]) np[win] = 1'b0;
                    m_phase = P_NUM;
                end
            end
            P_NUM: m_phase = P_SVC;
            default: if (eoi) m_phase = P_IDLE;
        endcase
        for (int i = 0; i < N; i++) begin
            if (m_mode[i] ? (irq[i] && !m_prev[i]) : irq[i]) np[i] = 1'b1;
        end
        if (wr && addr == 2'd0) m_mask = wdata[N-1:0];
        if (wr && addr == 2'd1) m_mode = wdata[N-1:0];
        m_pend = np;
        m_prev = irq;
    endtask

    task automatic checkOutput();
        checkValue("model active",   32'(active),  32'(m_phase == P_REQ));
        checkValue("model valid",    32'(valid),   32'(m_phase == P_NUM));
        checkValue("model service",  32'(in_svc),  32'(m_phase == P_SVC));
        checkValue("model number",   32'(num),     32'(m_id));
        checkValue("model cfg_data", 32'(cfg_out), 32'(m_cfg));
    endtask

    always @(posedge clk) modelStep();
    always @(negedge clk) if (model_on) checkOutput();

    task automatic applyStimulus(input logic r, input logic [N-1:0] i, input logic a, input logic e,
                                 input logic w, input logic [1:0] ad, input logic [DW-1:0] d);
        rst = r; irq = i; ack = a; eoi = e; wr = w; addr = ad; wdata = d;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] rnd_irq;
        repeat (2) @(negedge clk);
        model_on = 1'b1;
        checkValue("reset active",  32'(active),  32'd0);
        checkValue("reset valid",   32'(valid),   32'd0);
        checkValue("reset service", 32'(in_svc),  32'd0);
        checkValue("reset number",  32'(num),     32'd0);
        checkValue("reset cfg",     32'(cfg_out), 32'd0);

        // Single level line 3
        applyStimulus(0, 8'h00, 0, 0, 1, 2'd0, 16'h00FF);
        applyStimulus(0, 8'h08, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("l3 active early", 32'(active), 32'd0);
        applyStimulus(0, 8'h08, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("l3 active", 32'(active), 32'd1);
        applyStimulus(0, 8'h00, 1, 0, 0, 2'd0, 16'h0000);
        checkValue("l3 valid",  32'(valid), 32'd1);
        checkValue("l3 number", 32'(num),   32'd3);
        applyStimulus(0, 8'h00, 0, 0, 1, 2'd2, 16'h00FF);
        checkValue("l3 service", 32'(in_svc), 32'd1);
        checkValue("l3 hold number", 32'(num), 32'd3);
        applyStimulus(0, 8'h00, 0, 1, 0, 2'd0, 16'h0000);
        checkValue("l3 eoi service", 32'(in_svc), 32'd0);
        applyStimulus(0, 8'h00, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("l3 idle active", 32'(active), 32'd0);

        // Lines 2 and 5 together: 2 first, then 5
        applyStimulus(0, 8'h24, 0, 0, 0, 2'd0, 16'h0000);
        applyStimulus(0, 8'h00, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("pri active", 32'(active), 32'd1);
        applyStimulus(0, 8'h00, 1, 0, 0, 2'd0, 16'h0000);
        checkValue("pri first number", 32'(num), 32'd2);
        applyStimulus(0, 8'h00, 0, 0, 1, 2'd2, 16'h0004);
        applyStimulus(0, 8'h00, 0, 1, 0, 2'd0, 16'h0000);
        applyStimulus(0, 8'h00, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("pri second active", 32'(active), 32'd1);
        applyStimulus(0, 8'h00, 1, 0, 0, 2'd0, 16'h0000);
        checkValue("pri second number", 32'(num), 32'd5);
        applyStimulus(0, 8'h00, 0, 0, 1, 2'd2, 16'h0020);
        applyStimulus(0, 8'h00, 0, 1, 0, 2'd0, 16'h0000);

        // Edge line 0 pulse: pending set, cleared by ack
        applyStimulus(0, 8'h00, 0, 0, 1, 2'd1, 16'h0001);
        applyStimulus(0, 8'h01, 0, 0, 0, 2'd2, 16'h0000);
        applyStimulus(0, 8'h00, 0, 0, 0, 2'd2, 16'h0000);
        checkValue("edge pending", 32'(cfg_out), 32'h0001);
        checkValue("edge active",  32'(active),  32'd1);
        applyStimulus(0, 8'h00, 1, 0, 0, 2'd2, 16'h0000);
        checkValue("edge number", 32'(num), 32'd0);
        applyStimulus(0, 8'h00, 0, 0, 0, 2'd2, 16'h0000);
        checkValue("edge pending cleared", 32'(cfg_out), 32'h0000);
        applyStimulus(0, 8'h00, 0, 1, 0, 2'd2, 16'h0000);
        applyStimulus(0, 8'h00, 0, 0, 1, 2'd1, 16'h0000);

        // Everything masked, then unmask line 7 only
        applyStimulus(0, 8'h00, 0, 0, 1, 2'd0, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 8'hFF, 0, 0, 0, 2'd0, 16'h0000);
            checkValue("masked active", 32'(active), 32'd0);
        end
        checkValue("mask readback", 32'(cfg_out), 32'h0000);
        applyStimulus(0, 8'hFF, 0, 0, 1, 2'd0, 16'h0080);
        applyStimulus(0, 8'hFF, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("unmask active",   32'(active),  32'd1);
        checkValue("unmask readback", 32'(cfg_out), 32'h0080);
        applyStimulus(0, 8'hFF, 1, 0, 0, 2'd0, 16'h0000);
        checkValue("unmask number", 32'(num), 32'd7);
        applyStimulus(0, 8'h00, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("unmask service", 32'(in_svc), 32'd1);

        // Reset in the middle of service
        applyStimulus(1, 8'h00, 0, 0, 0, 2'd0, 16'h0000);
        checkValue("rst service", 32'(in_svc),  32'd0);
        checkValue("rst cfg",     32'(cfg_out), 32'd0);
        for (int a = 0; a < 4; a++) begin
            applyStimulus(0, 8'h00, 0, 0, 0, 2'(a), 16'h0000);
            checkValue("rst readback", 32'(cfg_out), 32'd0);
        end

        // Randomized traffic; the model compare runs every cycle
        for (int c = 0; c < 3000; c++) begin
            rnd_irq = N'($urandom & $urandom);
            applyStimulus($urandom_range(0, 199) == 0, rnd_irq, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          2'($urandom_range(0, 3)), 16'($urandom));
        end
        applyStimulus(0, 8'h00, 0, 0, 0, 2'd0, 16'h0000);

        // Sixteen-line instance: top channel number
        rst16 = 1'b0; wr16 = 1'b1; addr16 = 2'd0; wdata16 = 16'hFFFF;
        @(negedge clk);
        checkValue("w16 reset active", 32'(active16), 32'd0);
        wr16 = 1'b0; irq16 = 16'h8000;
        @(negedge clk);
        @(negedge clk);
        checkValue("w16 active", 32'(active16), 32'd1);
        irq16 = 16'h0000; ack16 = 1'b1;
        @(negedge clk);
        checkValue("w16 valid",  32'(valid16), 32'd1);
        checkValue("w16 number", 32'(num16),   32'h000F);
        ack16 = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
